// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time game core: screen codes,
// FSM state type, PRNG constants and the score saturation helper.
package reaction_pkg;

   localparam logic [2:0] SCR_IDLE    = 3'd0;
   localparam logic [2:0] SCR_WAIT    = 3'd1;
   localparam logic [2:0] SCR_GO      = 3'd2;
   localparam logic [2:0] SCR_RESULT  = 3'd3;
   localparam logic [2:0] SCR_SUMMARY = 3'd4;
   localparam logic [2:0] SCR_FALSE   = 3'd5;

   // State encodings equal the screen codes so the state register drives the screen directly.
   typedef enum logic [2:0] {
      ST_IDLE    = SCR_IDLE,
      ST_WAIT    = SCR_WAIT,
      ST_GO      = SCR_GO,
      ST_RESULT  = SCR_RESULT,
      ST_SUMMARY = SCR_SUMMARY,
      ST_FALSE   = SCR_FALSE
   } state_e;

   // 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 (taps on bits 7,5,4,3).
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

   // Largest value representable in a w-bit score.
   function automatic int unsigned SCORE_SAT(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/reaction_ms_timer.sv
// Millisecond prescaler plus a loadable counter shared by the WAIT countdown
// and the GO reaction measurement. load_i clears the prescaler, so the first
// tick after a load lands CYCLES_PER_MS cycles later.
module reaction_ms_timer #(
   parameter int          CYCLES_PER_MS = 50000,
   parameter int          CNT_W         = 14,
   parameter int unsigned SAT_VAL       = 16383
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             down_i,
   output logic             tick_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int               PRE_W    = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_MS - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SAT_VAL);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o  = (pre_q == PRE_LAST);
   assign count_o = cnt_q;

   // Next prescaler/counter value: count down to 0 or up to saturation on each tick.
   always_comb begin
      pre_d = tick_o ? '0 : pre_q + PRE_W'(1);
      cnt_d = cnt_q;
      if (tick_o) begin
         if (down_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
         end else begin
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (load_i) begin
         pre_d = '0;
         cnt_d = load_val_i;
      end
   end

   // Prescaler and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/reaction_multi.sv
// Multi-round reaction-time game core: random wait, GO, reaction measurement
// in ms, false-start detection, per-game average and best-average high score.
// Optional macro REACTION_FALSE_START_PENALTY_EN: a false start is scored as
// the saturated time instead of being retried.
module reaction_multi
   import reaction_pkg::*;
#(
   parameter int CYCLES_PER_MS = 50000,
   parameter int SCORE_W       = 14,
   parameter int ROUNDS        = 4,
   parameter int MIN_DELAY_MS  = 1000,
   parameter int DELAY_STEP_MS = 8
) (
   input  logic                     clk,
   input  logic                     iReset,
   input  logic                     spacePressed,
   input  logic                     onePressed,
   output logic [2:0]               screen,
   output logic [$clog2(ROUNDS):0]  roundIdx,
   output logic [SCORE_W-1:0]       currentScore,
   output logic [SCORE_W-1:0]       averageScore,
   output logic [SCORE_W-1:0]       highScore,
   output logic                     falseStart
);

   localparam int          LOG2R   = $clog2(ROUNDS);
   localparam int          RIDX_W  = LOG2R + 1;
   localparam int          SUM_W   = SCORE_W + LOG2R;
   localparam int unsigned SAT     = SCORE_SAT(SCORE_W);
   localparam int          DLY_MAX = MIN_DELAY_MS + 255 * DELAY_STEP_MS;
   localparam int          DLY_W   = $clog2(DLY_MAX + 1);
   localparam int          CNT_W   = (DLY_W > SCORE_W) ? DLY_W : SCORE_W;

   localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(SAT);
   localparam logic [CNT_W-1:0]   CNT_SAT_M1 = CNT_W'(SAT - 1);

   logic [1:0]         rst_sync_q;
   logic               rst_n;
   logic [7:0]         lfsr_q;
   state_e             state_q, state_d;
   logic [RIDX_W-1:0]  round_q, round_d;
   logic [SUM_W-1:0]   sum_q, sum_d, sum_fin;
   logic [SCORE_W-1:0] cur_q, cur_d;
   logic [SCORE_W-1:0] avg_q, avg_d, avg_new;
   logic [SCORE_W-1:0] high_q, high_d;
   logic               advance;
   logic               tick;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   dly_val;

   // Reset synchronizer: asserts immediately, releases two clocks after iReset rises.
   always_ff @(posedge clk or negedge iReset) begin
      if (!iReset) rst_sync_q <= '0;
      else         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   // Free-running PRNG that supplies the random part of each wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_next(lfsr_q);
   end

   assign dly_val = CNT_W'(MIN_DELAY_MS + int'(lfsr_q) * DELAY_STEP_MS);

   reaction_ms_timer #(
      .CYCLES_PER_MS (CYCLES_PER_MS),
      .CNT_W         (CNT_W),
      .SAT_VAL       (SAT)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (state_d != state_q),
      .load_val_i ((state_d == ST_WAIT) ? dly_val : '0),
      .down_i     (state_q == ST_WAIT),
      .tick_o     (tick),
      .count_o    (cnt)
   );

   // Game FSM next state plus score accumulation and high-score update.
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      sum_d   = sum_q;
      cur_d   = cur_q;
      avg_d   = avg_q;
      high_d  = high_q;
      sum_fin = sum_q;
      avg_new = '0;
      advance = 1'b0;

      if (onePressed) begin
         state_d = ST_IDLE;
         round_d = '0;
         sum_d   = '0;
         cur_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_SUMMARY: begin
               if (spacePressed) begin
                  state_d = ST_WAIT;
                  round_d = '0;
                  sum_d   = '0;
               end
            end
            ST_WAIT: begin
               if (spacePressed)                    state_d = ST_FALSE;
               else if (tick && cnt <= CNT_W'(1))   state_d = ST_GO;
            end
            ST_GO: begin
               if (spacePressed) begin
                  cur_d   = cnt[SCORE_W-1:0];
                  sum_fin = sum_q + SUM_W'(cnt[SCORE_W-1:0]);
                  sum_d   = sum_fin;
                  state_d = ST_RESULT;
               end else if (tick && cnt == CNT_SAT_M1) begin
                  cur_d   = SCORE_MAX;
                  sum_fin = sum_q + SUM_W'(SCORE_MAX);
                  sum_d   = sum_fin;
                  state_d = ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (spacePressed) advance = 1'b1;
            end
            ST_FALSE: begin
               if (spacePressed) begin
`ifdef REACTION_FALSE_START_PENALTY_EN
                  cur_d   = SCORE_MAX;
                  sum_fin = sum_q + SUM_W'(SCORE_MAX);
                  sum_d   = sum_fin;
                  advance = 1'b1;
`else
                  state_d = ST_WAIT;
`endif
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (advance) begin
            if (round_q < RIDX_W'(ROUNDS - 1)) begin
               round_d = round_q + RIDX_W'(1);
               state_d = ST_WAIT;
            end else begin
               avg_new = SCORE_W'(sum_fin >> LOG2R);
               avg_d   = avg_new;
               if (avg_new != '0 && (high_q == '0 || avg_new < high_q)) high_d = avg_new;
               state_d = ST_SUMMARY;
            end
         end
      end
   end

   // FSM and score registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         round_q <= '0;
         sum_q   <= '0;
         cur_q   <= '0;
         avg_q   <= '0;
         high_q  <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         sum_q   <= sum_d;
         cur_q   <= cur_d;
         avg_q   <= avg_d;
         high_q  <= high_d;
      end
   end

   assign screen       = state_q;
   assign roundIdx     = round_q;
   assign currentScore = cur_q;
   assign averageScore = avg_q;
   assign highScore    = high_q;
   assign falseStart   = (state_q == ST_FALSE);

endmodule

// File: tb/tb_reaction_multi.sv
// Bench for reaction_multi with CYCLES_PER_MS=2, ROUNDS=2, MIN_DELAY_MS=3,
// DELAY_STEP_MS=1. A second instance with SCORE_W=4 covers GO saturation.
module tb_reaction_multi;

   localparam int C     = 2;
   localparam int R     = 2;
   localparam int MINMS = 3;
   localparam int STEP  = 1;
   localparam int SW    = 14;
   localparam int SAT   = 16383;

   logic        clk, iReset, sp, one, sp4, one4;
   logic [2:0]  screen, screen4;
   logic [1:0]  roundIdx, round4;
   logic [13:0] cur, avg, high;
   logic [3:0]  cur4, avg4, high4;
   logic        fs, fs4;

   reaction_multi #(.CYCLES_PER_MS(C), .SCORE_W(SW), .ROUNDS(R),
                    .MIN_DELAY_MS(MINMS), .DELAY_STEP_MS(STEP)) dut (
      .clk(clk), .iReset(iReset), .spacePressed(sp), .onePressed(one),
      .screen(screen), .roundIdx(roundIdx), .currentScore(cur),
      .averageScore(avg), .highScore(high), .falseStart(fs));

   reaction_multi #(.CYCLES_PER_MS(C), .SCORE_W(4), .ROUNDS(R),
                    .MIN_DELAY_MS(MINMS), .DELAY_STEP_MS(STEP)) dut4 (
      .clk(clk), .iReset(iReset), .spacePressed(sp4), .onePressed(one4),
      .screen(screen4), .roundIdx(round4), .currentScore(cur4),
      .averageScore(avg4), .highScore(high4), .falseStart(fs4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int L      = 0;
   bit cal    = 1'b0;
   int entry_cyc = 0;
   int rand_fails = 0;

   // Reference model: elapsed-cycle arithmetic per state, no prescaler/counter.
   int m_state, m_entry, m_delay, m_round, m_sum, m_cur, m_avg, m_high;

   typedef struct {
      int t0;
      int t1;
      int exp_avg;
      int exp_high;
   } game_t;
   game_t games[3];

   function automatic int lfsr_after(input int k);
      logic [7:0] v;
      v = 8'hA5;
      for (int i = 0; i < k; i++) v = {v[6:0], ^(v & 8'hB8)};
      return int'(v);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic model_reset();
      m_state = 0; m_entry = 0; m_delay = 0; m_round = 0;
      m_sum = 0; m_cur = 0; m_avg = 0; m_high = 0;
   endtask

   task automatic m_finish(output int nxt);
      if (m_round < R - 1) begin
         m_round++;
         nxt = 1;
      end else begin
         m_avg = m_sum / R;
         if (m_avg != 0 && (m_high == 0 || m_avg < m_high)) m_high = m_avg;
         nxt = 4;
      end
   endtask

   task automatic model_step(input bit s, input bit o, input int n);
      int e, nxt;
      e   = n - m_entry;
      nxt = m_state;
      if (o) begin
         nxt = 0; m_round = 0; m_sum = 0; m_cur = 0;
      end else begin
         case (m_state)
            0, 4: if (s) begin nxt = 1; m_round = 0; m_sum = 0; end
            1: begin
               if (s) nxt = 5;
               else if (e == C * m_delay) nxt = 2;
            end
            2: begin
               if (s) begin
                  m_cur = (e - 1) / C; m_sum += m_cur; nxt = 3;
               end else if (e == C * SAT) begin
                  m_cur = SAT; m_sum += SAT; nxt = 3;
               end
            end
            3: if (s) m_finish(nxt);
            5: if (s) begin
`ifdef REACTION_FALSE_START_PENALTY_EN
               m_cur = SAT; m_sum += SAT;
               m_finish(nxt);
`else
               nxt = 1;
`endif
            end
            default: nxt = 0;
         endcase
      end
      if (nxt != m_state) begin
         m_entry = n;
         if (nxt == 1) m_delay = MINMS + lfsr_after(n - L) * STEP;
      end
      m_state = nxt;
   endtask

   task automatic tick();
      @(posedge clk);
      if (iReset) begin
         cyc++;
         model_step(sp, one, cyc);
      end
      #1;
   endtask

   task automatic press();
      sp = 1'b1;
      tick();
      sp = 1'b0;
      entry_cyc = cyc;
   endtask

   task automatic wait_go();
      bit got;
      int d;
      got = 1'b0;
      for (int i = 0; i < 600 && !got; i++) begin
         tick();
         if (screen == 3'd2) got = 1'b1;
      end
      if (!got) begin
         chk("go_timeout_screen", screen, 2);
      end else begin
         d = cyc - entry_cyc;
         if (!cal) begin
            for (int l = 0; l < 8; l++)
               if (!cal && C * (MINMS + lfsr_after(entry_cyc - l) * STEP) == d) begin
                  L = l;
                  cal = 1'b1;
               end
            chk("go_delay_in_prng_sequence", int'(cal), 1);
         end else begin
            chk("go_delay", d, C * (MINMS + lfsr_after(entry_cyc - L) * STEP));
         end
      end
   endtask

   task automatic react(input int ms);
      repeat (ms * C) tick();
      press();
      chk("react_score", cur, ms);
      chk("react_screen", screen, 3);
   endtask

   task automatic do_reset();
      iReset = 1'b0;
      #1;
      model_reset();
      cyc = 0;
      repeat (3) tick();
      @(negedge clk);
      iReset = 1'b1;
      repeat (10) tick();
   endtask

   initial begin
      int hs_exp, avg_exp;
      bit got4;
      bit mism;

      games[0] = '{t0: 10, t1: 21, exp_avg: 15, exp_high: 15};
      games[1] = '{t0: 12, t1: 13, exp_avg: 12, exp_high: 12};
      games[2] = '{t0: 19, t1: 21, exp_avg: 20, exp_high: 12};

      sp = 1'b0; one = 1'b0; sp4 = 1'b0; one4 = 1'b0;
      iReset = 1'b0;
      model_reset();
      #1;
      chk("rst_screen", screen, 0);
      chk("rst_round", roundIdx, 0);
      chk("rst_cur", cur, 0);
      chk("rst_avg", avg, 0);
      chk("rst_high", high, 0);
      chk("rst_falsestart", fs, 0);
      do_reset();
      chk("idle_screen", screen, 0);

      // Table-driven games.
      for (int g = 0; g < 3; g++) begin
         press();
         chk("game_start_screen", screen, 1);
         chk("game_start_round", roundIdx, 0);
         for (int r = 0; r < R; r++) begin
            wait_go();
            react((r == 0) ? games[g].t0 : games[g].t1);
            chk("result_round", roundIdx, r);
            press();
            if (r < R - 1) chk("next_round_screen", screen, 1);
         end
         chk("summary_screen", screen, 4);
         chk("summary_avg", avg, games[g].exp_avg);
         chk("summary_high", high, games[g].exp_high);
      end

      // False start.
      press();
      chk("fs_wait_screen", screen, 1);
      repeat (3) tick();
      press();
      chk("fs_screen", screen, 5);
      chk("fs_flag", fs, 1);
      chk("fs_round", roundIdx, 0);
      press();
      chk("fs_continue_screen", screen, 1);
      chk("fs_flag_cleared", fs, 0);
`ifdef REACTION_FALSE_START_PENALTY_EN
      chk("fs_penalty_round", roundIdx, 1);
      chk("fs_penalty_score", cur, SAT);
      wait_go();
      react(1);
      press();
      chk("fs_penalty_summary", screen, 4);
      chk("fs_penalty_avg", avg, 8192);
      chk("fs_penalty_high", high, 12);
      hs_exp = 12; avg_exp = 8192;
`else
      chk("fs_retry_round", roundIdx, 0);
      wait_go();
      react(5);
      press();
      wait_go();
      react(7);
      press();
      chk("fs_retry_summary", screen, 4);
      chk("fs_retry_avg", avg, 6);
      chk("fs_retry_high", high, 6);
      hs_exp = 6; avg_exp = 6;
`endif

      // onePressed beats spacePressed in GO.
      press();
      wait_go();
      repeat (3) tick();
      sp = 1'b1; one = 1'b1;
      tick();
      sp = 1'b0; one = 1'b0;
      chk("abort_screen", screen, 0);
      chk("abort_round", roundIdx, 0);
      chk("abort_cur", cur, 0);
      chk("abort_high_kept", high, hs_exp);
      chk("abort_avg_kept", avg, avg_exp);

      // Reset asserted mid-WAIT clears outputs without a clock edge.
      press();
      repeat (3) tick();
      iReset = 1'b0;
      #1;
      chk("midrst_screen", screen, 0);
      chk("midrst_round", roundIdx, 0);
      chk("midrst_high", high, 0);
      chk("midrst_avg", avg, 0);
      do_reset();

      // Saturation with SCORE_W=4.
      sp4 = 1'b1;
      tick();
      sp4 = 1'b0;
      got4 = 1'b0;
      for (int i = 0; i < 600 && !got4; i++) begin
         tick();
         if (screen4 == 3'd2) got4 = 1'b1;
      end
      if (!got4) begin
         chk("sat_go_timeout_screen", screen4, 2);
      end else begin
         repeat (15 * C - 1) tick();
         chk("sat_still_go", screen4, 2);
         tick();
         chk("sat_result_screen", screen4, 3);
         chk("sat_score", cur4, 15);
      end

      // Randomized run against the reference model.
      do_reset();
      for (int i = 0; i < 6000; i++) begin
         if (m_state == 1) sp = ($urandom_range(0, 599) == 0);
         else              sp = ($urandom_range(0, 19) == 0);
         one = ($urandom_range(0, 1499) == 0);
         tick();
         sp = 1'b0; one = 1'b0;
         mism = (int'(screen) != m_state) || (int'(roundIdx) != m_round) ||
                (int'(cur) != m_cur) || (int'(avg) != m_avg) ||
                (int'(high) != m_high) || (int'(fs) != int'(m_state == 5));
         total++;
         if (!mism) passed++;
         else begin
            rand_fails++;
            if (rand_fails <= 20)
               $display("FAIL rand_cycle %0d: got scr=%0d rnd=%0d cur=%0d avg=%0d hi=%0d, expected scr=%0d rnd=%0d cur=%0d avg=%0d hi=%0d",
                        i, screen, roundIdx, cur, avg, high,
                        m_state, m_round, m_cur, m_avg, m_high);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/reaction_multi.md
Name: reaction_multi

Overview:
- Next-generation reaction-time game core. Runs ROUNDS timed rounds per game.
- Each round: the block waits a pseudo-random delay, then shows GO and measures the reaction time in milliseconds.
- Detects false starts, accumulates per-round times, computes the game average, and keeps a best-average high score.
- Sits under the game-select top level and drives the display/VGA screen mux and the score-to-BCD path.

Parameters:
- CYCLES_PER_MS, 50000, clk cycles per millisecond tick (≥1).
- SCORE_W, 14, width of every score output, in ms.
- ROUNDS, 4, rounds per game; must be a power of two, ≥1.
- MIN_DELAY_MS, 1000, fixed part of the random wait.
- DELAY_STEP_MS, 8, ms per PRNG LSB added to the wait.

Ports:
- clk  in  1  system clock
- iReset  in  1  asynchronous, active-low reset
- spacePressed  in  1  one-cycle pulse, already debounced; start/react/continue
- onePressed  in  1  one-cycle pulse; abort to IDLE
- screen  out  3  screen code, encodings below
- roundIdx  out  $clog2(ROUNDS)+1  current round, 0-based
- currentScore  out  SCORE_W  last round time, ms
- averageScore  out  SCORE_W  average of last completed game, ms
- highScore  out  SCORE_W  best (lowest) average; 0 = none yet
- falseStart  out  1  high while in FALSE_START

Behaviour:
- Reset (async assert, sync deassert inside): state IDLE; all outputs 0.
- Screen encodings: IDLE=0, WAIT=1, GO=2, RESULT=3, SUMMARY=4, FALSE_START=5. screen is registered and changes 1 cycle after the causing input.
- ms tick: prescaler counts 0..CYCLES_PER_MS-1 and pulses on wrap. The prescaler is cleared on every state entry, so the first tick lands CYCLES_PER_MS cycles after entry.
- onePressed in any state → IDLE; roundIdx, sum and currentScore cleared; averageScore/highScore kept. onePressed beats spacePressed in the same cycle.
- IDLE + space → WAIT, roundIdx=0, sum=0.
- WAIT entry:
  - Load delay = MIN_DELAY_MS + PRNG[7:0]*DELAY_STEP_MS, using the 8-bit internal LFSR. LFSR is free-running, reset seed 8'hA5, never 0.
  - Decrement once per tick; at 0 → GO.
  - space while in WAIT, including the cycle the delay hits 0 → FALSE_START.
- GO:
  - Counter starts at 0 and increments per tick, saturating at 2^SCORE_W-1.
  - space → RESULT; currentScore ← counter; sum += counter.
  - Saturation with no press → RESULT with the saturated value.
- RESULT + space:
  - if roundIdx < ROUNDS-1 → roundIdx++, WAIT;
  - else → SUMMARY with averageScore = sum >> log2(ROUNDS). Sum width is SCORE_W+log2(ROUNDS); no overflow is possible.
  - highScore ← averageScore if highScore==0 or averageScore<highScore. An average of 0 never updates it.
- SUMMARY + space → WAIT as a new game (roundIdx=0, sum=0).
- FALSE_START + space → WAIT with the same roundIdx; sum unchanged.
- Reset mid-game: immediate IDLE; highScore lost.

Optional Feature:
- Macro: REACTION_FALSE_START_PENALTY_EN.
- Defined: FALSE_START + space scores the round as 2^SCORE_W-1. currentScore and sum are updated, and the block proceeds exactly as RESULT + space.
- Undefined: the round is retried as specified above.

Decomposition:
- Package reaction_pkg holds:
  - screen code localparams (SCR_IDLE … SCR_FALSE);
  - LFSR seed 8'hA5 and taps (x^8+x^6+x^5+x^4+1);
  - SCORE_SAT helper function.
- Sub-module reaction_ms_timer: prescaler plus a loadable down/up counter with saturate. It is instantiated once and shared by WAIT and GO.
- Game FSM and accumulator live in the top.

Test Plan (CYCLES_PER_MS=2, ROUNDS=2, MIN_DELAY_MS=3, DELAY_STEP_MS=1):
- Release reset → screen=0, all scores 0. Pulse space → screen=1 next cycle. GO arrives after exactly 2*(3+PRNG[7:0]) cycles.
- In GO, press space after 10 ticks → currentScore=10, screen=3.
- Round times 10 and 21 → averageScore=15, highScore=15. Next game with 12 and 13 → highScore=12; a following game averaging 20 leaves highScore=12.
- space during WAIT → screen=5, falseStart=1. Then space → WAIT with roundIdx unchanged. With the macro defined: currentScore=16383, and after round 2 (time 1) average=8192.
- No press in GO with SCORE_W=4 → currentScore=15 after 15 ticks, screen=3.
- onePressed together with space in GO → screen=0, roundIdx=0, highScore retained. Reset asserted mid-WAIT → all outputs 0 asynchronously.
